// File: rtl/arm_pkg.sv
// arm_pkg: shared types, widths and rotate helper for the rotated-immediate encoder.
// The INV_SEARCH state exists only when IMM_INVERT_EN is defined.
package arm_pkg;
   localparam int ROT_STEPS = 16;
   localparam int IMM_W     = 8;
   localparam int ROT_W     = 4;

`ifdef IMM_INVERT_EN
   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_INV_SEARCH, S_DONE} enc_state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} enc_state_t;
`endif

   function automatic logic [31:0] rol32(input logic [31:0] value, input logic [4:0] amount);
      logic [63:0] w_dbl;
      w_dbl = {value, value} << amount;
      return w_dbl[63:32];
   endfunction
endpackage

// File: rtl/imm_rot_check.sv
// imm_rot_check: tests one rotation candidate k; hit when ROL(value, 2k) fits in 8 bits.
module imm_rot_check
   import arm_pkg::*;
(
   input  logic [31:0]      value,
   input  logic [ROT_W-1:0] k,
   output logic             hit,
   output logic [IMM_W-1:0] imm8
);
   logic [31:0] w_rot;

   assign w_rot = rol32(value, {k, 1'b0});
   assign hit   = (w_rot[31:IMM_W] == '0);
   assign imm8  = w_rot[IMM_W-1:0];
endmodule

// File: rtl/imm_operand_encoder.sv
// imm_operand_encoder: iterative search for an ARM {rot4, imm8} encoding of a 32-bit constant.
// Optional MVN-form fallback search on ~value when IMM_INVERT_EN is defined.
module imm_operand_encoder
   import arm_pkg::*;
#(
   parameter int SEARCH_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_value,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_encodable,
   output logic [11:0] out_shift_operand,
   output logic        out_inverted
);
   enc_state_t       r_state, w_nxt_state;
   logic [31:0]      r_val, w_nxt_val, w_val;
   logic [ROT_W-1:0] r_rot, w_nxt_rot, w_k_sel;
   logic [IMM_W-1:0] w_imm_sel;
   logic [11:0]      r_so, w_nxt_so;
   logic             r_enc, w_nxt_enc, r_inv, w_nxt_inv, w_any, w_last, w_inv_phase;
   logic [ROT_W-1:0] w_k   [SEARCH_PER_CYCLE];
   logic             w_hit [SEARCH_PER_CYCLE];
   logic [IMM_W-1:0] w_imm [SEARCH_PER_CYCLE];

`ifdef IMM_INVERT_EN
   assign w_inv_phase = (r_state == S_INV_SEARCH);
`else
   assign w_inv_phase = 1'b0;
`endif
   assign w_val  = w_inv_phase ? ~r_val : r_val;
   assign w_last = (r_rot == ROT_W'(ROT_STEPS - SEARCH_PER_CYCLE));

   for (genvar g = 0; g < SEARCH_PER_CYCLE; g++) begin : g_chk
      assign w_k[g] = r_rot + ROT_W'(g);
      imm_rot_check u_chk (.value(w_val), .k(w_k[g]), .hit(w_hit[g]), .imm8(w_imm[g]));
   end

   // Scan high to low so the lowest hit index wins (canonical encoding).
   always_comb begin
      w_any     = 1'b0;
      w_k_sel   = '0;
      w_imm_sel = '0;
      for (int i = SEARCH_PER_CYCLE - 1; i >= 0; i--)
         if (w_hit[i]) begin
            w_any     = 1'b1;
            w_k_sel   = w_k[i];
            w_imm_sel = w_imm[i];
         end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_val   = r_val;
      w_nxt_rot   = r_rot;
      w_nxt_enc   = r_enc;
      w_nxt_so    = r_so;
      w_nxt_inv   = r_inv;
      if (r_state == S_IDLE) begin
         if (in_valid) begin
            w_nxt_state = S_SEARCH;
            w_nxt_val   = in_value;
            w_nxt_rot   = '0;
            w_nxt_enc   = 1'b0;
            w_nxt_so    = '0;
            w_nxt_inv   = 1'b0;
         end
      end else if (r_state == S_DONE) begin
         if (out_ready) w_nxt_state = S_IDLE;
      end else if (w_any) begin
         w_nxt_state = S_DONE;
         w_nxt_enc   = 1'b1;
         w_nxt_so    = {w_k_sel, w_imm_sel};
         w_nxt_inv   = w_inv_phase;
      end else if (w_last) begin
`ifdef IMM_INVERT_EN
         w_nxt_state = w_inv_phase ? S_DONE : S_INV_SEARCH;
`else
         w_nxt_state = S_DONE;
`endif
         w_nxt_rot   = '0;
         w_nxt_enc   = 1'b0;
         w_nxt_so    = '0;
         w_nxt_inv   = 1'b0;
      end else begin
         w_nxt_rot   = r_rot + ROT_W'(SEARCH_PER_CYCLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_val   <= '0;
         r_rot   <= '0;
         r_enc   <= 1'b0;
         r_so    <= '0;
         r_inv   <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_val   <= w_nxt_val;
         r_rot   <= w_nxt_rot;
         r_enc   <= w_nxt_enc;
         r_so    <= w_nxt_so;
         r_inv   <= w_nxt_inv;
      end
   end

   assign in_ready          = (r_state == S_IDLE);
   assign out_valid         = (r_state == S_DONE);
   assign out_encodable     = r_enc;
   assign out_shift_operand = r_so;
   assign out_inverted      = r_inv;
endmodule

// File: tb/tb_imm_operand_encoder.sv
// tb_imm_operand_encoder: scoreboard bench for imm_operand_encoder (latency, result, backpressure, reset).
// Expectations follow the IMM_INVERT_EN macro when it is defined for the build.
module tb_imm_operand_encoder;
   localparam int K = 1;

   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_value = '0;
   logic        in_ready, out_valid, out_encodable, out_inverted;
   logic [11:0] out_shift_operand;

   typedef struct {logic enc; logic [11:0] so; logic inv; int lat;} exp_t;
   exp_t sb[$];
   int checks = 0, errors = 0;

   imm_operand_encoder #(.SEARCH_PER_CYCLE(K)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
      .out_valid(out_valid), .out_ready(out_ready), .out_encodable(out_encodable),
      .out_shift_operand(out_shift_operand), .out_inverted(out_inverted));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
      return (s == 0) ? v : ((v << s) | (v >> (32 - s)));
   endfunction

   function automatic logic [31:0] rotr(input logic [31:0] v, input int s);
      return (s == 0) ? v : ((v >> s) | (v << (32 - s)));
   endfunction

   function automatic exp_t mk(input logic enc, input logic [11:0] so, input logic inv, input int lat);
      exp_t e;
      e.enc = enc; e.so = so; e.inv = inv; e.lat = lat;
      return e;
   endfunction

   function automatic exp_t model(input logic [31:0] v);
      logic [31:0] t;
      for (int k = 0; k < 16; k++) begin
         t = rotl(v, 2 * k);
         if (t < 32'h100) return mk(1'b1, {k[3:0], t[7:0]}, 1'b0, (k + K) / K);
      end
`ifdef IMM_INVERT_EN
      for (int k = 0; k < 16; k++) begin
         t = rotl(~v, 2 * k);
         if (t < 32'h100) return mk(1'b1, {k[3:0], t[7:0]}, 1'b1, 16 / K + (k + K) / K);
      end
      return mk(1'b0, 12'h000, 1'b0, 32 / K);
`else
      return mk(1'b0, 12'h000, 1'b0, 16 / K);
`endif
   endfunction

   // Called at a negedge in IDLE; returns at the negedge after acceptance.
   task automatic issue(input logic [31:0] v, input exp_t e);
      check("in_ready_idle", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_value = v;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      check("in_ready_busy", {31'b0, in_ready}, 32'd0);
   endtask

   task automatic wait_result(input logic [31:0] v);
      int n;
      exp_t e;
      logic [31:0] dec;
      n = 0;
      while (!out_valid && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("out_valid", {31'b0, out_valid}, 32'd1);
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check("latency", n, e.lat);
      check("encodable", {31'b0, out_encodable}, {31'b0, e.enc});
      check("shift_operand", {20'b0, out_shift_operand}, {20'b0, e.so});
      check("inverted", {31'b0, out_inverted}, {31'b0, e.inv});
      if (out_encodable) begin
         dec = rotr({24'b0, out_shift_operand[7:0]}, 2 * int'(out_shift_operand[11:8]));
         check("decode", dec, out_inverted ? ~v : v);
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_drop", {31'b0, out_valid}, 32'd0);
      check("in_ready_back", {31'b0, in_ready}, 32'd1);
   endtask

   task automatic run(input logic [31:0] v, input exp_t e);
      issue(v, e);
      wait_result(v);
      release_out();
   endtask

   initial begin
      logic [31:0] v;
      #1;
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_encodable", {31'b0, out_encodable}, 32'd0);
      check("rst_so", {20'b0, out_shift_operand}, 32'd0);
      check("rst_inverted", {31'b0, out_inverted}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run(32'h000000FF, mk(1'b1, 12'h0FF, 1'b0, 1));
      run(32'hFF000000, mk(1'b1, 12'h4FF, 1'b0, (4 + K) / K));
      run(32'hF000000F, mk(1'b1, 12'h2FF, 1'b0, (2 + K) / K));
      run(32'h00000000, mk(1'b1, 12'h000, 1'b0, 1));
`ifdef IMM_INVERT_EN
      run(32'h00000101, mk(1'b0, 12'h000, 1'b0, 32 / K));
      run(32'hFFFFFF00, mk(1'b1, 12'h0FF, 1'b1, 16 / K + 1));
`else
      run(32'h00000101, mk(1'b0, 12'h000, 1'b0, 16 / K));
      run(32'hFFFFFF00, mk(1'b0, 12'h000, 1'b0, 16 / K));
`endif

      // Backpressure: hold result, offer a competing request that must be ignored.
      issue(32'h000000AB, mk(1'b1, 12'h0AB, 1'b0, 1));
      wait_result(32'h000000AB);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_value = 32'h3FC00000;
         @(negedge clk);
         check("bp_valid", {31'b0, out_valid}, 32'd1);
         check("bp_so", {20'b0, out_shift_operand}, 32'h0AB);
         check("bp_enc", {31'b0, out_encodable}, 32'd1);
         check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      release_out();
      run(32'h0000FF00, mk(1'b1, 12'hCFF, 1'b0, (12 + K) / K));

      // Reset during the third search cycle of an unencodable value.
      in_valid = 1'b1;
      in_value = 32'h00000101;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("mid_rst_encodable", {31'b0, out_encodable}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run(32'h3FC00000, mk(1'b1, 12'h5FF, 1'b0, (5 + K) / K));

      // Random sweep: half built from a legal encoding, half arbitrary.
      for (int i = 0; i < 24; i++) begin
         if (i % 2 == 0) v = rotr({24'b0, 8'($urandom_range(0, 255))}, 2 * int'($urandom_range(0, 15)));
         else v = $urandom;
         run(v, model(v));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
